// File: rtl/uart_rx_buf.sv
// uart_rx_buf: 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx_buf #(
   parameter int DEPTH = 8,
   parameter int DIV_W = 16
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   input  logic                   rx_i,
   input  logic [DIV_W-1:0]       clk_div,
   output logic [7:0]             rx_data,
   output logic                   rx_valid,
   input  logic                   rx_ready,
   output logic [$clog2(DEPTH):0] rx_count,
   output logic                   rx_busy,
   output logic                   frame_err,
   output logic                   overflow,
   input  logic                   err_clr,
`ifdef UART_RX_PARITY_EN
   output logic                   parity_err,
`endif
   output logic                   irq
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
`ifdef UART_RX_PARITY_EN
      , S_PARITY
`endif
   } state_t;

   state_t           r_state;
   state_t           w_state_nx;
   logic             r_sync1;
   logic             r_sync2;
   logic             r_prev;
   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] r_cnt;
   logic [DIV_W-1:0] w_div_in;
   logic [7:0]       r_shift;
   logic [7:0]       r_pdata;
   logic [2:0]       r_idx;
   logic             r_push;
   logic             r_ferr;
   logic             r_ovf;
   logic [AW:0]      r_wr;
   logic [AW:0]      r_rd;
   logic [7:0]       r_mem [DEPTH];
   logic             w_fall;
   logic             w_tick;
   logic             w_load_half;
   logic             w_load_full;
   logic             w_shift_en;
   logic             w_push;
   logic             w_ferr_set;
   logic             w_full;
   logic             w_empty;
   logic             w_pop;
   logic             w_wr_en;
   logic             w_ovf_set;
`ifdef UART_RX_PARITY_EN
   logic             r_bad;
   logic             r_perr;
   logic             w_par_smp;
   logic             w_perr_set;
`endif

   assign w_div_in = (clk_div < DIV_W'(4)) ? DIV_W'(4) : clk_div;
   assign w_fall   = r_prev & ~r_sync2;
   assign w_tick   = (r_cnt == '0);

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_prev  <= 1'b1;
      end else begin
         r_sync1 <= rx_i;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) r_state <= S_IDLE;
      else          r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx  = r_state;
      w_load_half = 1'b0;
      w_load_full = 1'b0;
      w_shift_en  = 1'b0;
      w_push      = 1'b0;
      w_ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_smp   = 1'b0;
      w_perr_set  = 1'b0;
`endif
      unique case (r_state)
         S_IDLE: begin
            if (w_fall) begin
               w_state_nx  = S_START;
               w_load_half = 1'b1;
            end
         end
         S_START: begin
            if (w_tick) begin
               if (!r_sync2) begin
                  w_state_nx  = S_DATA;
                  w_load_full = 1'b1;
               end else begin
                  w_state_nx  = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (w_tick) begin
               w_shift_en  = 1'b1;
               w_load_full = 1'b1;
`ifdef UART_RX_PARITY_EN
               if (r_idx == 3'd7) w_state_nx = S_PARITY;
`else
               if (r_idx == 3'd7) w_state_nx = S_STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (w_tick) begin
               w_par_smp   = 1'b1;
               w_perr_set  = ^{r_shift, r_sync2};
               w_load_full = 1'b1;
               w_state_nx  = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (w_tick) begin
               if (r_sync2) begin
`ifdef UART_RX_PARITY_EN
                  w_push = ~r_bad;
`else
                  w_push = 1'b1;
`endif
                  w_state_nx = S_IDLE;
               end else begin
                  w_ferr_set = 1'b1;
                  w_state_nx = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            if (r_sync2) w_state_nx = S_IDLE;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   // Down-counter: the half load lands the first tick on mid start bit.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_div   <= DIV_W'(4);
         r_cnt   <= '0;
         r_shift <= '0;
         r_idx   <= '0;
      end else begin
         if (w_load_half) begin
            r_div <= w_div_in;
            r_cnt <= (w_div_in >> 1) - DIV_W'(1);
            r_idx <= '0;
         end else if (w_load_full) begin
            r_cnt <= r_div - DIV_W'(1);
         end else if (!w_tick) begin
            r_cnt <= r_cnt - DIV_W'(1);
         end
         if (w_shift_en) begin
            r_shift[r_idx] <= r_sync2;
            r_idx          <= r_idx + 3'd1;
         end
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_push  <= 1'b0;
         r_pdata <= '0;
      end else begin
         r_push  <= w_push;
         r_pdata <= r_shift;
      end
   end

   assign w_empty = (r_wr == r_rd);
   assign w_full  = (r_wr[AW] != r_rd[AW]) &&
                    (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign w_pop     = rx_valid & rx_ready;
   assign w_wr_en   = r_push & (~w_full | w_pop);
   assign w_ovf_set = r_push & w_full & ~w_pop;

   always_ff @(posedge wb_clk_i) begin
      if (w_wr_en) r_mem[r_wr[AW-1:0]] <= r_pdata;
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (w_wr_en) r_wr <= r_wr + 1'b1;
         if (w_pop)   r_rd <= r_rd + 1'b1;
      end
   end

   // Set wins over a coincident clear.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_ferr <= 1'b0;
         r_ovf  <= 1'b0;
      end else begin
         if (w_ferr_set)   r_ferr <= 1'b1;
         else if (err_clr) r_ferr <= 1'b0;
         if (w_ovf_set)    r_ovf  <= 1'b1;
         else if (err_clr) r_ovf  <= 1'b0;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_bad  <= 1'b0;
         r_perr <= 1'b0;
      end else begin
         if (w_load_half)    r_bad <= 1'b0;
         else if (w_par_smp) r_bad <= w_perr_set;
         if (w_perr_set)     r_perr <= 1'b1;
         else if (err_clr)   r_perr <= 1'b0;
      end
   end

   assign parity_err = r_perr;
   assign irq        = rx_valid | r_ferr | r_ovf | r_perr;
`else
   assign irq        = rx_valid | r_ferr | r_ovf;
`endif

   assign rx_valid  = ~w_empty;
   assign rx_data   = w_empty ? 8'h00 : r_mem[r_rd[AW-1:0]];
   assign rx_count  = r_wr - r_rd;
   assign rx_busy   = (r_state != S_IDLE);
   assign frame_err = r_ferr;
   assign overflow  = r_ovf;

endmodule
